// File: rtl/mem_arbiter_if.sv
// Request/response bus shared by the fetch, load/store and memory sides of
// mem_arbiter. The requester drives the master modport; the responder
// uses the slave modport.
interface mem_arbiter_if;
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, wen, addr, wdata, wmask,
        input  ready, rdata
    );

    modport slave (
        input  req, wen, addr, wdata, wmask,
        output ready, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (ifu) and
// load/store (lsu). A winning request is latched for the whole transaction.
// The response is passed straight back to the winner. A watchdog ends a
// transaction that has waited TIMEOUT cycles without mem.ready and pulses err.
//
// Optional feature macro: ARB_RR_EN.
//   Defined:   round-robin on conflict, tracked by a 1-bit last-grant register.
//   Undefined: fixed priority, so LSU always wins a conflict.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  ifu,
    mem_arbiter_if.slave  lsu,
    mem_arbiter_if.master mem,
    output logic          err
);

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IFU = 2'd1,
        BUSY_LSU = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic        wen_q, wen_d;
    logic [15:0] cnt_q, cnt_d;

    logic        grant_ifu;
    logic        grant_lsu;
    logic        done;
    logic        expire;
    logic [31:0] resp_rdata;

`ifdef ARB_RR_EN
    // 1 = LSU held the most recent grant, 0 = IFU
    logic        last_grant_q, last_grant_d;
`endif

    // The fetch bus never carries write fields; fetches latch zeros instead
    logic        unused_ifu_fields;
    assign unused_ifu_fields = ^{ifu.wen, ifu.wdata, ifu.wmask};

    // Arbitration decode: only meaningful in IDLE, where requests are sampled
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (ifu.req && lsu.req) begin
`ifdef ARB_RR_EN
                grant_lsu = !last_grant_q;
                grant_ifu = last_grant_q;
`else
                grant_lsu = 1'b1;
`endif
            end else begin
                grant_ifu = ifu.req;
                grant_lsu = lsu.req;
            end
        end
    end

    // Next-state logic, request latching, watchdog and response pass-through
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        cnt_d      = cnt_q;
        done       = 1'b0;
        expire     = 1'b0;
        resp_rdata = 32'h0;
`ifdef ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_lsu) begin
                    state_d = BUSY_LSU;
                    addr_d  = lsu.addr;
                    wdata_d = lsu.wdata;
                    wmask_d = lsu.wmask;
                    wen_d   = lsu.wen;
                    cnt_d   = 16'd0;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (grant_ifu) begin
                    state_d = BUSY_IFU;
                    addr_d  = ifu.addr;
                    wdata_d = 32'h0;
                    wmask_d = 8'h0;
                    wen_d   = 1'b0;
                    cnt_d   = 16'd0;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            BUSY_IFU, BUSY_LSU: begin
                // A real response on the expiry cycle takes precedence
                if (mem.ready) begin
                    done       = 1'b1;
                    resp_rdata = mem.rdata;
                    state_d    = IDLE;
                end else if (cnt_q == TIMEOUT_C) begin
                    done    = 1'b1;
                    expire  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wmask_q <= 8'h0;
            wen_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant register, cleared to IFU so the first conflict goes to LSU
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Memory side is driven only from state and latched fields
    assign mem.req   = (state_q != IDLE);
    assign mem.wen   = wen_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.wmask = wmask_q;

    // Requester side: same-cycle completion, zero data when not ready
    assign ifu.ready = done && (state_q == BUSY_IFU);
    assign lsu.ready = done && (state_q == BUSY_LSU);
    assign ifu.rdata = ifu.ready ? resp_rdata : 32'h0;
    assign lsu.rdata = lsu.ready ? resp_rdata : 32'h0;
    assign err       = expire;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT=4). It runs directed scenarios
// and then a randomized run that is checked against a transaction-level model.
module tb_mem_arbiter;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    logic err;

    mem_arbiter_if ifu_bus ();
    mem_arbiter_if lsu_bus ();
    mem_arbiter_if mem_bus ();

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .mem (mem_bus),
        .err (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_last_lsu;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    // Puts the DUT in reset and clears all requester and memory inputs
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_bus.req = 0; ifu_bus.wen = 0; ifu_bus.addr = 0; ifu_bus.wdata = 0; ifu_bus.wmask = 0;
        lsu_bus.req = 0; lsu_bus.wen = 0; lsu_bus.addr = 0; lsu_bus.wdata = 0; lsu_bus.wmask = 0;
        mem_bus.ready = 0; mem_bus.rdata = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last_lsu = 1'b0;
    endtask

    // Acts as the memory until one transaction completes. Responds lat cycles
    // after mem_req rises and records what the arbiter presented. Only
    // observations are returned here; the calling test makes the comparisons.
    task automatic serve(input int lat, input logic [31:0] rd, input bit hold_ifu, input bit hold_lsu,
                         output int idle_cyc, output int busy_cyc,
                         output bit saw_ifu, output bit saw_lsu, output bit saw_err,
                         output logic [31:0] rdata_o, output logic wen_o,
                         output logic [31:0] addr_o, output logic [31:0] wdata_o,
                         output logic [7:0] wmask_o, output bit stable_o,
                         output bit spurious_o, output bit idle_after_o, output bit timed_out_o);
        int  k;
        bit  fin;
        k = 0; fin = 0;
        idle_cyc = 0; busy_cyc = 0;
        saw_ifu = 0; saw_lsu = 0; saw_err = 0; rdata_o = 0;
        wen_o = 0; addr_o = 0; wdata_o = 0; wmask_o = 0;
        stable_o = 1; spurious_o = 0; idle_after_o = 0; timed_out_o = 1;
        for (int it = 0; it < 200 && !fin; it++) begin
            if (mem_bus.req !== 1'b1) begin
                mem_bus.ready = 1'($urandom_range(0, 1));
                mem_bus.rdata = $urandom;
                idle_cyc++;
                #1;
                if (ifu_bus.ready || lsu_bus.ready || err) spurious_o = 1;
            end else begin
                if (k == 0) begin
                    wen_o = mem_bus.wen; addr_o = mem_bus.addr;
                    wdata_o = mem_bus.wdata; wmask_o = mem_bus.wmask;
                end else if (mem_bus.wen !== wen_o || mem_bus.addr !== addr_o ||
                             mem_bus.wdata !== wdata_o || mem_bus.wmask !== wmask_o) begin
                    stable_o = 0;
                end
                mem_bus.ready = (k == lat);
                mem_bus.rdata = (k == lat) ? rd : $urandom;
                busy_cyc++;
                #1;
                if ((!ifu_bus.ready && ifu_bus.rdata !== 32'h0) ||
                    (!lsu_bus.ready && lsu_bus.rdata !== 32'h0)) spurious_o = 1;
                if (ifu_bus.ready || lsu_bus.ready || err) begin
                    saw_ifu = ifu_bus.ready;
                    saw_lsu = lsu_bus.ready;
                    saw_err = err;
                    rdata_o = ifu_bus.ready ? ifu_bus.rdata : lsu_bus.rdata;
                    fin = 1;
                    timed_out_o = 0;
                end
                k++;
            end
            @(negedge clk);
        end
        mem_bus.ready = 0;
        if (saw_ifu && !hold_ifu) ifu_bus.req = 0;
        if (saw_lsu && !hold_lsu) lsu_bus.req = 0;
        #1;
        idle_after_o = (mem_bus.req === 1'b0);
    endtask

    // Observation variables shared by the directed tests (used sequentially)
    int          o_idle, o_busy;
    bit          o_ifu, o_lsu, o_err, o_stable, o_spur, o_idle_after, o_tmo;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic        o_wen;
    logic [7:0]  o_wmask;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_bus.req = 1; lsu_bus.req = 1;
        mem_bus.ready = 1; mem_bus.rdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (mem_bus.req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_bus.req); else n_pass++;
        n_checks++; if (ifu_bus.ready !== 1'b0 || lsu_bus.ready !== 1'b0) $display("FAIL reset_ready got=%b%b exp=00", ifu_bus.ready, lsu_bus.ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
        n_checks++; if (mem_bus.addr !== 32'h0 || mem_bus.wen !== 1'b0) $display("FAIL reset_fields got=%h/%b exp=0/0", mem_bus.addr, mem_bus.wen); else n_pass++;
        do_reset();
        mem_bus.ready = 1;
        #1;
        n_checks++; if (ifu_bus.ready !== 1'b0 || lsu_bus.ready !== 1'b0) $display("FAIL idle_stray_ready got=%b%b exp=00", ifu_bus.ready, lsu_bus.ready); else n_pass++;
        mem_bus.ready = 0;
        $display("txn reset: done");
    endtask

    task automatic test_single_fetch();
        do_reset();
        ifu_bus.req = 1; ifu_bus.addr = 32'h80000000;
        serve(3, 32'h00000413, 0, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
              o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
        n_checks++; if (o_tmo !== 0) $display("FAIL fetch_done got=timeout exp=complete"); else n_pass++;
        n_checks++; if (o_idle !== 1) $display("FAIL fetch_grant_latency got=%0d exp=1", o_idle); else n_pass++;
        n_checks++; if (o_addr !== 32'h80000000 || o_wen !== 1'b0) $display("FAIL fetch_mem_fields got=%h/%b exp=80000000/0", o_addr, o_wen); else n_pass++;
        n_checks++; if (o_ifu !== 1 || o_lsu !== 0) $display("FAIL fetch_ready got=ifu%b lsu%b exp=ifu1 lsu0", o_ifu, o_lsu); else n_pass++;
        n_checks++; if (o_rdata !== 32'h00000413) $display("FAIL fetch_rdata got=%h exp=00000413", o_rdata); else n_pass++;
        n_checks++; if (o_busy !== 4 || o_err !== 0) $display("FAIL fetch_busy got=%0d err%b exp=4 err0", o_busy, o_err); else n_pass++;
        n_checks++; if (o_idle_after !== 1 || o_spur !== 0) $display("FAIL fetch_after got=idle%b spur%b exp=idle1 spur0", o_idle_after, o_spur); else n_pass++;
        $display("txn fetch: addr=%h rdata=%h busy=%0d", o_addr, o_rdata, o_busy);
    endtask

    task automatic test_store();
        do_reset();
        lsu_bus.req = 1; lsu_bus.wen = 1; lsu_bus.addr = 32'h80001000;
        lsu_bus.wdata = 32'hCAFEF00D; lsu_bus.wmask = 8'h0F;
        serve(2, 32'h0, 0, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
              o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
        n_checks++; if (o_wen !== 1 || o_addr !== 32'h80001000 || o_wdata !== 32'hCAFEF00D || o_wmask !== 8'h0F)
            $display("FAIL store_fields got=%b/%h/%h/%h exp=1/80001000/cafef00d/0f", o_wen, o_addr, o_wdata, o_wmask); else n_pass++;
        n_checks++; if (o_stable !== 1) $display("FAIL store_stable got=0 exp=1"); else n_pass++;
        n_checks++; if (o_lsu !== 1 || o_ifu !== 0 || o_busy !== 3) $display("FAIL store_ready got=lsu%b ifu%b busy%0d exp=lsu1 ifu0 busy3", o_lsu, o_ifu, o_busy); else n_pass++;
        $display("txn store: addr=%h wdata=%h wmask=%h", o_addr, o_wdata, o_wmask);
    endtask

    task automatic test_conflict();
        bit exp_lsu [3];
`ifdef ARB_RR_EN
        exp_lsu = '{1'b1, 1'b0, 1'b1};
`else
        exp_lsu = '{1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        ifu_bus.req = 1; ifu_bus.addr = 32'h00001000;
        lsu_bus.req = 1; lsu_bus.addr = 32'h00002000; lsu_bus.wen = 0;
        for (int t = 0; t < 3; t++) begin
            serve(1, 32'h100 + t, 1, 1, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
                  o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
            n_checks++; if (o_lsu !== exp_lsu[t] || o_ifu !== !exp_lsu[t])
                $display("FAIL conflict_grant%0d got=lsu%b ifu%b exp=lsu%b", t, o_lsu, o_ifu, exp_lsu[t]); else n_pass++;
            n_checks++; if (o_addr !== (exp_lsu[t] ? 32'h00002000 : 32'h00001000))
                $display("FAIL conflict_addr%0d got=%h", t, o_addr); else n_pass++;
            $display("txn conflict %0d: lsu=%b ifu=%b", t, o_lsu, o_ifu);
        end
        ifu_bus.req = 0; lsu_bus.req = 0;
    endtask

    task automatic test_watchdog();
        do_reset();
        ifu_bus.req = 1; ifu_bus.addr = 32'h80000040;
        serve(1000, 32'hFFFFFFFF, 0, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
              o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
        n_checks++; if (o_ifu !== 1 || o_err !== 1 || o_rdata !== 32'h0)
            $display("FAIL watchdog_pulse got=ready%b err%b rdata%h exp=1/1/0", o_ifu, o_err, o_rdata); else n_pass++;
        n_checks++; if (o_busy !== TMO + 1) $display("FAIL watchdog_busy got=%0d exp=%0d", o_busy, TMO + 1); else n_pass++;
        n_checks++; if (o_idle_after !== 1) $display("FAIL watchdog_idle got=0 exp=1"); else n_pass++;
        #2;
        n_checks++; if (err !== 1'b0) $display("FAIL watchdog_err_width got=%b exp=0", err); else n_pass++;
        $display("txn watchdog: busy=%0d err=%b", o_busy, o_err);
    endtask

    task automatic test_tie();
        do_reset();
        lsu_bus.req = 1; lsu_bus.wen = 0; lsu_bus.addr = 32'h80000100;
        serve(TMO, 32'h12345678, 0, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
              o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
        n_checks++; if (o_lsu !== 1 || o_err !== 0 || o_rdata !== 32'h12345678)
            $display("FAIL tie_expiry got=ready%b err%b rdata%h exp=1/0/12345678", o_lsu, o_err, o_rdata); else n_pass++;
        n_checks++; if (o_busy !== TMO + 1) $display("FAIL tie_busy got=%0d exp=%0d", o_busy, TMO + 1); else n_pass++;
        $display("txn tie: rdata=%h err=%b", o_rdata, o_err);
    endtask

    task automatic test_reset_mid();
        bit entered;
        do_reset();
        lsu_bus.req = 1; lsu_bus.wen = 1; lsu_bus.addr = 32'h80002000;
        lsu_bus.wdata = 32'h55AA55AA; lsu_bus.wmask = 8'hFF;
        entered = 0;
        for (int i = 0; i < 10 && !entered; i++) begin
            @(negedge clk);
            entered = (mem_bus.req === 1'b1);
        end
        n_checks++; if (!entered) $display("FAIL rstmid_grant got=no mem_req exp=mem_req"); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (mem_bus.req !== 1'b0) $display("FAIL rstmid_mem_req got=%b exp=0", mem_bus.req); else n_pass++;
        rst = 1'b0; lsu_bus.req = 0;
        @(negedge clk);
        mem_bus.ready = 1; mem_bus.rdata = 32'h0BADF00D;
        #1;
        n_checks++; if (lsu_bus.ready !== 1'b0 || ifu_bus.ready !== 1'b0 || err !== 1'b0)
            $display("FAIL rstmid_stray got=lsu%b ifu%b err%b exp=000", lsu_bus.ready, ifu_bus.ready, err); else n_pass++;
        @(negedge clk);
        mem_bus.ready = 0;
        #1;
        n_checks++; if (mem_bus.req !== 1'b0) $display("FAIL rstmid_stay_idle got=%b exp=0", mem_bus.req); else n_pass++;
        $display("txn reset_mid: mem_req=%b", mem_bus.req);
    endtask

    task automatic test_back_to_back();
        do_reset();
        ifu_bus.req = 1; ifu_bus.addr = 32'h80000200;
        for (int t = 0; t < 3; t++) begin
            serve(0, 32'hA0 + t, 1, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
                  o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
            n_checks++; if (o_idle !== 1 || o_busy !== 1 || o_ifu !== 1 || o_rdata !== 32'hA0 + t)
                $display("FAIL b2b%0d got=idle%0d busy%0d ready%b rdata%h exp=1/1/1/%h", t, o_idle, o_busy, o_ifu, o_rdata, 32'hA0 + t); else n_pass++;
            $display("txn b2b %0d: idle=%0d busy=%0d", t, o_idle, o_busy);
        end
        ifu_bus.req = 0;
    endtask

    // Randomized traffic against a transaction-level model: each master holds
    // a pending request until served; the model decides the winner from the
    // arbitration rule and the outcome from the response latency vs TIMEOUT.
    task automatic test_random();
        bit          p_ifu, p_lsu, win_lsu, exp_err;
        logic [31:0] i_addr, l_addr, l_wdata, rd, e_addr, e_wdata, e_rdata;
        logic [7:0]  l_wmask, e_wmask;
        logic        l_wen, e_wen;
        int          lat, e_busy;
        do_reset();
        p_ifu = 0; p_lsu = 0;
        for (int t = 0; t < 40; t++) begin
            if (!p_ifu && ($urandom_range(0, 1) == 1)) begin
                p_ifu = 1; i_addr = $urandom;
                ifu_bus.req = 1; ifu_bus.addr = i_addr;
                ifu_bus.wen = 1'($urandom_range(0, 1)); ifu_bus.wdata = $urandom; ifu_bus.wmask = 8'($urandom);
            end
            if (!p_lsu && (!p_ifu || $urandom_range(0, 1) == 1)) begin
                p_lsu = 1; l_addr = $urandom; l_wdata = $urandom; l_wmask = 8'($urandom);
                l_wen = 1'($urandom_range(0, 1));
                lsu_bus.req = 1; lsu_bus.addr = l_addr; lsu_bus.wdata = l_wdata;
                lsu_bus.wmask = l_wmask; lsu_bus.wen = l_wen;
            end
`ifdef ARB_RR_EN
            win_lsu = (p_ifu && p_lsu) ? !model_last_lsu : p_lsu;
`else
            win_lsu = p_lsu;
`endif
            model_last_lsu = win_lsu;
            e_addr  = win_lsu ? l_addr  : i_addr;
            e_wdata = win_lsu ? l_wdata : 32'h0;
            e_wmask = win_lsu ? l_wmask : 8'h0;
            e_wen   = win_lsu ? l_wen   : 1'b0;
            lat = $urandom_range(0, 6);
            rd  = $urandom;
            exp_err = (lat > TMO);
            e_busy  = (exp_err ? TMO : lat) + 1;
            e_rdata = exp_err ? 32'h0 : rd;
            serve(lat, rd, 0, 0, o_idle, o_busy, o_ifu, o_lsu, o_err, o_rdata, o_wen,
                  o_addr, o_wdata, o_wmask, o_stable, o_spur, o_idle_after, o_tmo);
            n_checks++; if (o_lsu !== win_lsu || o_ifu !== !win_lsu)
                $display("FAIL rnd%0d_winner got=lsu%b ifu%b exp=lsu%b", t, o_lsu, o_ifu, win_lsu); else n_pass++;
            n_checks++; if (o_addr !== e_addr || o_wdata !== e_wdata || o_wmask !== e_wmask || o_wen !== e_wen)
                $display("FAIL rnd%0d_fields got=%h/%h/%h/%b exp=%h/%h/%h/%b", t, o_addr, o_wdata, o_wmask, o_wen, e_addr, e_wdata, e_wmask, e_wen); else n_pass++;
            n_checks++; if (o_rdata !== e_rdata || o_err !== exp_err || o_busy !== e_busy)
                $display("FAIL rnd%0d_resp got=%h err%b busy%0d exp=%h err%b busy%0d", t, o_rdata, o_err, o_busy, e_rdata, exp_err, e_busy); else n_pass++;
            n_checks++; if (o_idle !== 1 || o_stable !== 1 || o_spur !== 0 || o_idle_after !== 1 || o_tmo !== 0)
                $display("FAIL rnd%0d_protocol got=idle%0d stable%b spur%b after%b tmo%b exp=1/1/0/1/0", t, o_idle, o_stable, o_spur, o_idle_after, o_tmo); else n_pass++;
            $display("txn rnd %0d: win=%s addr=%h lat=%0d err=%b", t, win_lsu ? "lsu" : "ifu", o_addr, lat, o_err);
            if (win_lsu) p_lsu = 0; else p_ifu = 0;
        end
        ifu_bus.req = 0; lsu_bus.req = 0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_bus.req = 0; ifu_bus.wen = 0; ifu_bus.addr = 0; ifu_bus.wdata = 0; ifu_bus.wmask = 0;
        lsu_bus.req = 0; lsu_bus.wen = 0; lsu_bus.addr = 0; lsu_bus.wdata = 0; lsu_bus.wmask = 0;
        mem_bus.ready = 0; mem_bus.rdata = 0;
        model_last_lsu = 0;
        test_reset();
        test_single_fetch();
        test_store();
        test_conflict();
        test_watchdog();
        test_tie();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that shares the single data memory port between instruction fetch (IFU) and load/store (LSU). It sits between the fetch stage, the write-back/LSU path and the memory model. It serialises their requests onto one req/ready channel, latches the winning request for the whole transaction and routes the response back. A watchdog releases a hung transaction and flags an error.

## Interface
- TIMEOUT, 255: max BUSY cycles without mem_ready before forced completion; legal range 1..65535.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- ifu_req  in  1  fetch request, level, held until ifu_ready
- ifu_addr  in  32  fetch address
- ifu_ready  out  1  one-cycle completion pulse to IFU
- ifu_rdata  out  32  fetch data, valid when ifu_ready=1
- lsu_req  in  1  load/store request, level, held until lsu_ready
- lsu_wen  in  1  1=store, 0=load
- lsu_addr  in  32  access address
- lsu_wdata  in  32  store data
- lsu_wmask  in  8  store byte mask
- lsu_ready  out  1  one-cycle completion pulse to LSU
- lsu_rdata  out  32  load data, valid when lsu_ready=1
- mem_req  out  1  slave request, level, high for entire BUSY state
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/32/32/8  latched request fields
- mem_ready  in  1  slave completion pulse
- mem_rdata  in  32  slave read data, valid with mem_ready
- err  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, BUSY_IFU, BUSY_LSU.
- IDLE: if any req, pick a winner and latch its addr, wdata, wmask and wen. IFU latches wen=0, wdata=0, wmask=0. Go to BUSY_<winner>. If no req, stay in IDLE.
- Conflict (both req in IDLE): the winner is selected by the arbitration policy (see Configuration).
- BUSY_x: mem_req=1 and mem_* are driven from the latched fields, which stay stable while BUSY. Requester inputs are ignored.
- Completion: while in BUSY_x, mem_ready=1 gives x_ready=1 and x_rdata=mem_rdata in the same cycle (combinational pass-through), then the next state is IDLE.
- The non-granted ready output is 0. x_rdata is 0 when x_ready=0.
- A store completes identically; its rdata is don't-care.
- Requester drops req the cycle after ready. A req still high in IDLE is a new transaction.
- mem_ready in IDLE is ignored and causes no ready pulse.
- Watchdog:
  - 16-bit counter cleared on entry to BUSY; +1 per BUSY cycle with mem_ready=0.
  - When counter==TIMEOUT and mem_ready=0: force x_ready=1, x_rdata=32'h0, err=1, next state IDLE.
  - mem_ready in the same cycle wins: normal completion, err=0.
- Reset (any time, including mid-transaction):
  - State goes to IDLE; latched fields, counter and last_grant are cleared (last_grant=IFU).
  - mem_req=0, both ready=0, err=0 from the cycle after the rst edge.
  - A pending mem_ready arriving after reset is dropped.

## Timing
- Grant latency: req seen in IDLE at edge N gives mem_req=1 in cycle N+1.
- Response latency: 0 cycles from mem_ready to x_ready.
- Minimum transaction: 2 cycles (IDLE, BUSY with immediate mem_ready).
- Back-to-back: 1 IDLE bubble between transactions.
- All outputs except the x_ready/x_rdata/err pass-through are registered or decoded from state. No combinational path exists from req to mem_*.

## Configuration
- ARB_RR_EN defined: round-robin.
  - A 1-bit last_grant register is updated on every grant.
  - On conflict, grant the master that is not last_grant.
  - last_grant resets to IFU, so the first conflict grants LSU.
- ARB_RR_EN undefined: fixed priority, LSU always wins a conflict. last_grant is not implemented. IFU can starve while lsu_req stays continuously high.

## Test plan
- Single fetch:
  - Stimulus: ifu_req=1, ifu_addr=0x80000000; mem_ready returned 3 cycles after mem_req rises with mem_rdata=0x00000413.
  - Response: mem_addr=0x80000000 and mem_wen=0; ifu_ready pulses once with ifu_rdata=0x00000413; lsu_ready stays 0.
- Store:
  - Stimulus: lsu_req=1, lsu_wen=1, addr 0x80001000, wdata 0xCAFEF00D, wmask 0x0F.
  - Response: the mem_* fields match the request, stable for all BUSY cycles; lsu_ready pulses once.
- Conflict:
  - Stimulus: both req high together in IDLE, held through 3 transactions.
  - Response with ARB_RR_EN: grant order LSU, IFU, LSU.
  - Response without ARB_RR_EN: LSU, LSU, LSU.
- Watchdog:
  - Stimulus: TIMEOUT=4, mem_ready held 0.
  - Response: ifu_ready=1, ifu_rdata=0 and err=1 in the same cycle, 5 BUSY cycles after grant; next cycle IDLE.
- Tie at expiry: mem_ready arrives on the expiry cycle -> normal completion with mem_rdata, err=0.
- Reset mid-transaction: rst asserted in BUSY_LSU -> next cycle mem_req=0, state IDLE; a later stray mem_ready produces no ready pulse.
